// File: rtl/fdc_pkg.sv
// Shared definitions for the multichannel frequency-to-digital counter:
// FSM states, synchronizer depth and gate-window length decode.
package fdc_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int REF_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT
  } fdc_state_e;

  // Number of clk_ref rising edges that make up one gate window.
  function automatic logic [REF_CNT_W-1:0] win_edges(input logic [1:0] sel);
    return REF_CNT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/fdc_edge_sync.sv
// Brings an asynchronous input into the clk domain and emits a one-cycle
// pulse for each rising edge seen after synchronization.
module fdc_edge_sync
  import fdc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/fdc_multichan.sv
// Counts rising edges on N_CH oscillator inputs during a gate window of
// 2^win_sel clk_ref periods; single-shot or continuous back-to-back windows.
module fdc_multichan
  import fdc_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cont,
  input  logic [1:0]                win_sel,
  input  logic                      clk_ref,
  input  logic [N_CH-1:0]           vco,
  input  logic [$clog2(N_CH)-1:0]   ch_sel,
  output logic [CNT_W-1:0]          result,
  output logic                      overflow,
  output logic                      result_valid,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fdc_state_e           state_q, state_d;
  logic                 ref_pulse;
  logic [N_CH-1:0]      vco_pulse;
  logic [1:0]           win_q;
  logic [REF_CNT_W-1:0] ref_cnt_q;
  logic                 last_edge, open_win, close_win, cap_pend_q;

  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [CNT_W-1:0] cap_cnt_q [N_CH];
  logic [CNT_W-1:0] res_q     [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d, cap_ovf_q, res_ovf_q;

  fdc_edge_sync u_ref_sync (.clk(clk), .rst_n(rst_n), .din(clk_ref), .pulse(ref_pulse));

  for (genvar g = 0; g < N_CH; g++) begin : g_vco
    fdc_edge_sync u_sync (.clk(clk), .rst_n(rst_n), .din(vco[g]), .pulse(vco_pulse[g]));
  end

  assign last_edge = (ref_cnt_q == win_edges(win_q) - REF_CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Abort wins over a closing edge arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    open_win  = 1'b0;
    close_win = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ARM;
      ST_ARM: begin
        if (abort) state_d = ST_IDLE;
        else if (ref_pulse) begin
          state_d  = ST_COUNT;
          open_win = 1'b1;
        end
      end
      ST_COUNT: begin
        if (abort) state_d = ST_IDLE;
        else if (ref_pulse && last_edge) begin
          close_win = 1'b1;
          state_d   = cont ? ST_COUNT : ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Saturating increment; overflow marks an edge lost at full scale.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (vco_pulse[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= '0;
        cap_cnt_q[i] <= '0;
        res_q[i]     <= '0;
      end
      ovf_q        <= '0;
      cap_ovf_q    <= '0;
      res_ovf_q    <= '0;
      win_q        <= '0;
      ref_cnt_q    <= '0;
      cap_pend_q   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      cap_pend_q   <= close_win;
      result_valid <= cap_pend_q;
      // Snapshot at the closing edge so a reopening window can clear the counters.
      if (close_win) begin
        for (int i = 0; i < N_CH; i++) cap_cnt_q[i] <= cnt_d[i];
        cap_ovf_q <= ovf_d;
      end
      if (cap_pend_q) begin
        for (int i = 0; i < N_CH; i++) res_q[i] <= cap_cnt_q[i];
        res_ovf_q <= cap_ovf_q;
      end
      if (open_win) win_q <= win_sel;
      if (open_win || (close_win && cont)) begin
        for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        ovf_q     <= '0;
        ref_cnt_q <= '0;
      end else if (state_q == ST_COUNT) begin
        for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        ovf_q <= ovf_d;
        if (ref_pulse) ref_cnt_q <= ref_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (int'(ch_sel) < N_CH) begin
      result   = res_q[ch_sel];
      overflow = res_ovf_q[ch_sel];
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fdc_multichan.sv
// Directed bench for fdc_multichan: a default instance and a CNT_W=4 instance
// share all inputs so saturation can be observed alongside normal counting.
module tb_fdc_multichan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [1:0] win_sel = 2'd0;
  logic       clk_ref = 1'b0;
  logic [1:0] vco = 2'b00;
  logic [0:0] ch_sel = 1'b0;

  logic [7:0] result;
  logic       overflow, result_valid, busy;
  logic [3:0] result4;
  logic       overflow4, rv4, busy4;

  int vectors = 0;
  int miscompares = 0;
  int ref_per = 40;
  int vco_per0 = 0;
  int vco_per1 = 0;
  int tick = 0;

  fdc_multichan u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .win_sel(win_sel), .clk_ref(clk_ref), .vco(vco), .ch_sel(ch_sel),
    .result(result), .overflow(overflow), .result_valid(result_valid), .busy(busy)
  );

  fdc_multichan #(.N_CH(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .win_sel(win_sel), .clk_ref(clk_ref), .vco(vco), .ch_sel(ch_sel),
    .result(result4), .overflow(overflow4), .result_valid(rv4), .busy(busy4)
  );

  initial forever #5 clk = ~clk;

  // Reference and oscillator waveforms, all changing on the falling clk edge.
  initial forever begin
    @(negedge clk);
    tick++;
    clk_ref = (ref_per > 0 && (tick % ref_per) < ref_per / 2) ? 1'b1 : 1'b0;
    vco[0]  = (vco_per0 > 0 && (tick % vco_per0) < vco_per0 / 2) ? 1'b1 : 1'b0;
    vco[1]  = (vco_per1 > 0 && (tick % vco_per1) < vco_per1 / 2) ? 1'b1 : 1'b0;
  end

  task automatic wait_rv(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Issue start while clk_ref is low, then wait until the opening ref edge is on the pin.
  task automatic start_and_sync(output bit ok);
    bit prev;
    ok = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (prev && !clk_ref) begin ok = 1'b1; break; end
      prev = clk_ref;
    end
    if (ok) begin
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (clk_ref) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_result: got %0d expected 0", result); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", result_valid); end
    vectors++;
    if (busy !== 1'b0 || busy4 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", busy, busy4); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit got;
    int extra;
    ref_per = 40; vco_per0 = 8; vco_per1 = 0; win_sel = 2'd0; cont = 1'b0; ch_sel = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_arm: got %b expected 1", busy); end
    wait_rv(200, got);
    vectors++;
    if (!got) begin miscompares++; $display("[TB] FAIL single_valid_timeout: got none expected pulse"); end
    vectors++;
    if (result !== 8'd5) begin miscompares++; $display("[TB] FAIL single_result: got %0d expected 5", result); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL single_overflow: got %b expected 0", overflow); end
    vectors++;
    if (result4 !== 4'd5 || rv4 !== 1'b1) begin miscompares++; $display("[TB] FAIL single_cnt4: got %0d/%b expected 5/1", result4, rv4); end
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (result_valid) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("[TB] FAIL single_extra_valid: got %0d expected 0", extra); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
    @(negedge clk); ch_sel = 1'b1; #1;
    vectors++;
    if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL single_ch1_idle: got %0d expected 0", result); end
  endtask

  task automatic test_overflow();
    bit got;
    vco_per0 = 8; vco_per1 = 0; win_sel = 2'd2; cont = 1'b0; ch_sel = 1'b0;
    pulse_start();
    wait_rv(400, got);
    vectors++;
    if (!got) begin miscompares++; $display("[TB] FAIL ovf_valid_timeout: got none expected pulse"); end
    vectors++;
    if (result4 !== 4'd15 || overflow4 !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sat4: got %0d/%b expected 15/1", result4, overflow4); end
    vectors++;
    if (result !== 8'd20 || overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_wide: got %0d/%b expected 20/0", result, overflow); end
  endtask

  task automatic test_back_to_back();
    bit got, busy_drop;
    int pulses, cyc;
    int t[3];
    vco_per0 = 8; vco_per1 = 10; win_sel = 2'd0; cont = 1'b1; ch_sel = 1'b1;
    repeat (20) @(negedge clk);
    pulse_start();
    pulses = 0; cyc = 0; busy_drop = 1'b0;
    for (int i = 0; i < 400 && pulses < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) busy_drop = 1'b1;
      if (result_valid) begin
        t[pulses] = cyc;
        pulses++;
        vectors++;
        if (result !== 8'd4) begin miscompares++; $display("[TB] FAIL b2b_result%0d: got %0d expected 4", pulses, result); end
      end
    end
    vectors++;
    if (pulses !== 3) begin miscompares++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses); end
    else begin
      vectors++;
      if (t[1] - t[0] !== 40 || t[2] - t[1] !== 40) begin
        miscompares++; $display("[TB] FAIL b2b_spacing: got %0d,%0d expected 40,40", t[1] - t[0], t[2] - t[1]);
      end
    end
    vectors++;
    if (busy_drop) begin miscompares++; $display("[TB] FAIL b2b_busy: got low expected high"); end
    @(negedge clk); cont = 1'b0;
    wait_rv(100, got);
    vectors++;
    if (!got || result !== 8'd4) begin miscompares++; $display("[TB] FAIL b2b_last: got %b/%0d expected 1/4", got, result); end
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    bit ok;
    int extra;
    vco_per1 = 8; win_sel = 2'd0; cont = 1'b0; ch_sel = 1'b1;
    start_and_sync(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL abort_sync_timeout: got none expected ref edge"); end
    repeat (21) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_idle: got %b expected 0", busy); end
    extra = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (result_valid) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("[TB] FAIL abort_valid: got %0d expected 0", extra); end
    vectors++;
    if (result !== 8'd4 || overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_kept: got %0d/%b expected 4/0", result, overflow); end
  endtask

  task automatic test_start_busy_reset();
    bit ok, got;
    int extra;
    vco_per0 = 8; win_sel = 2'd0; cont = 1'b0; ch_sel = 1'b0;
    start_and_sync(ok);
    repeat (10) @(posedge clk);
    pulse_start();
    wait_rv(80, got);
    vectors++;
    if (!ok || !got || result !== 8'd5) begin miscompares++; $display("[TB] FAIL restart_ignored: got %b/%0d expected 1/5", got, result); end
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (result_valid || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("[TB] FAIL restart_idle: got %0d active cycles expected 0", extra); end
    start_and_sync(ok);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0 || result !== 8'd0 || overflow !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_outputs: got %b/%0d/%b/%b expected 0/0/0/0", busy, result, overflow, result_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (result_valid || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("[TB] FAIL midreset_release: got %0d active cycles expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_start_busy_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
